axil2iob: RTL and testbench

//  AXI4-Lite slave to native (IOb) master bridge; inverse of the native-to-AXI-Lite bridge.

---
 rtl/axil2iob_pkg.sv | 24 ++
 rtl/axil2iob.sv | 188 ++++++++++++++++++
 tb/tb_axil2iob.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil2iob_pkg.sv
// axil2iob_pkg
//   Shared AXI-Lite response/protection widths, the OKAY response code and
//   the bridge FSM state type used by axil2iob.
package axil2iob_pkg;

  localparam int AXI_RESP_W = 2;
  localparam int AXI_PROT_W = 3;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RRESP = 3'd4
  } state_e;

  // A native access with no byte enabled is a read; with any enabled, a write.
  function automatic logic strb_is_write(input logic [31:0] strb);
    return |strb;
  endfunction

endpackage

// File: rtl/axil2iob.sv
// axil2iob
//   AXI4-Lite slave to native (IOb) master bridge. Accepts one AXI-Lite
//   transaction at a time (AW+W or AR), issues a single native access with
//   iob_valid held until iob_ready, then returns the B or R response.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   s_axil_aw*               write address channel (awprot ignored)
//   s_axil_w*                write data channel
//   s_axil_b*                write response channel, bresp always OKAY
//   s_axil_ar*               read address channel (arprot ignored)
//   s_axil_r*                read data channel, rdata registered, rresp OKAY
//   iob_valid/addr/wdata/wstrb  native request (wstrb==0 means read)
//   iob_rdata/iob_ready      native completion; rdata sampled with ready
module axil2iob
  import axil2iob_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_W-1:0]     s_axil_awaddr,
  input  logic [AXI_PROT_W-1:0]      s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_DATA_W-1:0]     s_axil_wdata,
  input  logic [AXIL_DATA_W/8-1:0]   s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [AXI_RESP_W-1:0]      s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_W-1:0]     s_axil_araddr,
  input  logic [AXI_PROT_W-1:0]      s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_DATA_W-1:0]     s_axil_rdata,
  output logic [AXI_RESP_W-1:0]      s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       iob_valid,
  output logic [AXIL_ADDR_W-1:0]     iob_addr,
  output logic [AXIL_DATA_W-1:0]     iob_wdata,
  output logic [AXIL_DATA_W/8-1:0]   iob_wstrb,
  input  logic [AXIL_DATA_W-1:0]     iob_rdata,
  input  logic                       iob_ready
);

  state_e                      state_q, state_d;
  logic                        aw_got_q, aw_got_d;
  logic                        w_got_q, w_got_d;
  logic                        last_rd_q, last_rd_d;
  logic [AXIL_ADDR_W-1:0]      addr_q, addr_d;
  logic [AXIL_DATA_W-1:0]      wdata_q, wdata_d;
  logic [AXIL_DATA_W/8-1:0]    wstrb_q, wstrb_d;
  logic [AXIL_DATA_W-1:0]      rdata_q, rdata_d;

  logic idle;
  logic none_got;
  logic wr_req;
  logic rd_grant;
  logic wr_open;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // Protection bits carry no meaning for native peripherals.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  assign idle     = (state_q == ST_IDLE);
  assign none_got = !aw_got_q && !w_got_q;
  assign wr_req   = s_axil_awvalid || s_axil_wvalid;

  // A read can only win when no write half has been captured yet. When both
  // directions are pending, alternate: last grant was a read -> write wins.
  assign rd_grant = idle && none_got && s_axil_arvalid && (!wr_req || !last_rd_q);
  assign wr_open  = idle && !rd_grant;

  assign s_axil_awready = wr_open && !aw_got_q;
  assign s_axil_wready  = wr_open && !w_got_q;
  assign s_axil_arready = rd_grant;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign ar_hs = rd_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      last_rd_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      last_rd_q <= last_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    last_rd_d = last_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d    = s_axil_araddr;
          wstrb_d   = '0;
          last_rd_d = 1'b1;
          state_d   = ST_READ;
        end else begin
          // The first write half accepted from an empty state is the grant.
          if (none_got && (aw_hs || w_hs)) begin
            last_rd_d = 1'b0;
          end
          if (aw_hs) begin
            addr_d   = s_axil_awaddr;
            aw_got_d = 1'b1;
          end
          if (w_hs) begin
            wdata_d = s_axil_wdata;
            wstrb_d = s_axil_wstrb;
            w_got_d = 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            // An all-zero strobe would look like a read on the native side,
            // so it is acknowledged without touching the peripheral.
            state_d = strb_is_write(32'(wstrb_d)) ? ST_WRITE : ST_WRESP;
          end
        end
      end
      ST_WRITE: begin
        if (iob_ready) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (s_axil_bready) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_READ: begin
        if (iob_ready) begin
          rdata_d = iob_rdata;
          state_d = ST_RRESP;
        end
      end
      ST_RRESP: begin
        if (s_axil_rready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign iob_valid     = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign iob_addr      = addr_q;
  assign iob_wdata     = wdata_q;
  assign iob_wstrb     = wstrb_q;
  assign s_axil_bvalid = (state_q == ST_WRESP);
  assign s_axil_bresp  = RESP_OKAY;
  assign s_axil_rvalid = (state_q == ST_RRESP);
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axil2iob.sv
// tb_axil2iob
//   Directed bench for axil2iob: an AXI-Lite master driven from one initial
//   block, a native responder, and scoreboards of expected native accesses and
//   AXI responses checked when the DUT produces them.
module tb_axil2iob;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] s_axil_awaddr;
  logic [2:0]    s_axil_awprot;
  logic          s_axil_awvalid;
  logic          s_axil_awready;
  logic [DW-1:0] s_axil_wdata;
  logic [SW-1:0] s_axil_wstrb;
  logic          s_axil_wvalid;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready;
  logic [AW-1:0] s_axil_araddr;
  logic [2:0]    s_axil_arprot;
  logic          s_axil_arvalid;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready;
  logic          iob_valid;
  logic [AW-1:0] iob_addr;
  logic [DW-1:0] iob_wdata;
  logic [SW-1:0] iob_wstrb;
  logic [DW-1:0] iob_rdata;
  logic          iob_ready;

  axil2iob #(.AXIL_ADDR_W(AW), .AXIL_DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .iob_valid      (iob_valid),
    .iob_addr       (iob_addr),
    .iob_wdata      (iob_wdata),
    .iob_wstrb      (iob_wstrb),
    .iob_rdata      (iob_rdata),
    .iob_ready      (iob_ready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } nat_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } rsp_t;

  nat_t exp_nat[$];
  rsp_t exp_rsp[$];

  int   total     = 0;
  int   bad       = 0;
  int   rsp_seen  = 0;
  int   rdy_delay = 0;
  int   wait_cnt  = 0;
  logic hang      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Read data returned by the native peripheral model for a given address.
  function automatic logic [31:0] rd_map(input logic [31:0] a);
    if (a == 32'h24) return 32'h1234_5678;
    return {16'hA5A5, a[15:0]};
  endfunction

  // Native responder: ready pulse rdy_delay+1 cycles after valid is seen;
  // rdata carries a poison value except in the ready cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      iob_ready <= 1'b0;
      iob_rdata <= 32'hBAD0_BAD0;
      wait_cnt  <= 0;
    end else begin
      iob_ready <= 1'b0;
      iob_rdata <= 32'hBAD0_BAD0;
      if (iob_valid && !iob_ready && !hang) begin
        if (wait_cnt >= rdy_delay) begin
          iob_ready <= 1'b1;
          iob_rdata <= rd_map(iob_addr);
          wait_cnt  <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Native access monitor.
  logic [31:0] snap_addr  = '0;
  logic [31:0] snap_wdata = '0;
  logic [3:0]  snap_wstrb = '0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin : nat_mon
    nat_t e;
    if (iob_valid && !prev_valid) begin
      snap_addr  <= iob_addr;
      snap_wdata <= iob_wdata;
      snap_wstrb <= iob_wstrb;
    end
    prev_valid <= iob_valid;
    if (iob_valid && iob_ready) begin
      if (exp_nat.size() == 0) begin
        total++;
        bad++;
        $error("FAIL native_unexpected observed=addr 0x%08h wstrb 0x%h expected=no access", iob_addr, iob_wstrb);
      end else begin
        e = exp_nat.pop_front();
        $display("native %s addr=0x%08h wdata=0x%08h wstrb=0x%h", (iob_wstrb != 0) ? "WR" : "RD",
                 iob_addr, iob_wdata, iob_wstrb);
        chk("nat_kind", 32'(iob_wstrb != 4'h0), 32'(e.wr));
        chk("nat_addr", iob_addr, e.addr);
        chk("nat_wstrb", 32'(iob_wstrb), 32'(e.wstrb));
        if (e.wr) chk("nat_wdata", iob_wdata, e.wdata);
        chk("nat_addr_stable", iob_addr, snap_addr);
        chk("nat_wdata_stable", iob_wdata, snap_wdata);
        chk("nat_wstrb_stable", 32'(iob_wstrb), 32'(snap_wstrb));
      end
    end
  end

  // AXI response monitor.
  always @(negedge clk) begin : rsp_mon
    rsp_t r;
    if ((s_axil_bvalid && s_axil_bready) || (s_axil_rvalid && s_axil_rready)) begin
      if (exp_rsp.size() == 0) begin
        total++;
        bad++;
        $error("FAIL resp_unexpected observed=bvalid %0d rvalid %0d expected=no response",
               s_axil_bvalid, s_axil_rvalid);
      end else begin
        r = exp_rsp.pop_front();
        $display("resp %s data=0x%08h bresp=%0d rresp=%0d", s_axil_rvalid ? "R" : "B",
                 s_axil_rdata, s_axil_bresp, s_axil_rresp);
        chk("resp_kind", 32'(s_axil_rvalid), 32'(r.is_rd));
        if (r.is_rd) begin
          chk("rdata", s_axil_rdata, r.data);
          chk("rresp", 32'(s_axil_rresp), 32'(2'b00));
        end else begin
          chk("bresp", 32'(s_axil_bresp), 32'(2'b00));
        end
      end
      rsp_seen <= rsp_seen + 1;
    end
  end

  // Master channel drivers: called just after a rising edge, return just
  // after the edge on which the handshake happened.
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    s_axil_awaddr  = a;
    s_axil_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axil_awready && n < 100);
    if (!s_axil_awready) begin
      total++; bad++;
      $error("FAIL aw_timeout observed=awready 0 expected=awready 1");
    end
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axil_wdata  = d;
    s_axil_wstrb  = s;
    s_axil_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axil_wready && n < 100);
    if (!s_axil_wready) begin
      total++; bad++;
      $error("FAIL w_timeout observed=wready 0 expected=wready 1");
    end
    @(posedge clk); #1;
    s_axil_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    s_axil_araddr  = a;
    s_axil_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axil_arready && n < 100);
    if (!s_axil_arready) begin
      total++; bad++;
      $error("FAIL ar_timeout observed=arready 0 expected=arready 1");
    end
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_count", 32'(rsp_seen), 32'(target));
  endtask

  initial begin
    rst            = 1'b1;
    s_axil_awaddr  = '0;
    s_axil_awprot  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b1;
    s_axil_araddr  = '0;
    s_axil_arprot  = '0;
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iob_valid", 32'(iob_valid), 32'(0));
    chk("rst_bvalid", 32'(s_axil_bvalid), 32'(0));
    chk("rst_rvalid", 32'(s_axil_rvalid), 32'(0));
    chk("rst_iob_addr", iob_addr, 32'h0);
    chk("rst_iob_wdata", iob_wdata, 32'h0);
    chk("rst_iob_wstrb", 32'(iob_wstrb), 32'(0));
    chk("rst_rdata", s_axil_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: AW and W in the same cycle, native ready after a short wait
    rdy_delay = 2;
    exp_nat.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF});
    exp_rsp.push_back('{1'b0, 32'h0});
    fork
      send_aw(32'h10);
      send_w(32'hDEAD_BEEF, 4'hF);
    join
    @(negedge clk);
    chk("t1_iob_valid_latency", 32'(iob_valid), 32'(1));
    chk("t1_iob_addr", iob_addr, 32'h10);
    wait_rsp(1);

    // T2: W three cycles before AW
    exp_nat.push_back('{1'b1, 32'h20, 32'hCAFE_F00D, 4'h3});
    exp_rsp.push_back('{1'b0, 32'h0});
    send_w(32'hCAFE_F00D, 4'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_wready_low", 32'(s_axil_wready), 32'(0));
      chk("t2_no_iob_valid", 32'(iob_valid), 32'(0));
    end
    @(posedge clk); #1;
    send_aw(32'h20);
    wait_rsp(2);

    // T5: zero strobe write never reaches the native side
    s_axil_bready = 1'b0;
    exp_rsp.push_back('{1'b0, 32'h0});
    fork
      send_aw(32'h30);
      send_w(32'h5555_5555, 4'h0);
    join
    @(negedge clk);
    chk("t5_bvalid_latency", 32'(s_axil_bvalid), 32'(1));
    chk("t5_no_iob_valid", 32'(iob_valid), 32'(0));
    @(posedge clk); #1;
    s_axil_bready = 1'b1;
    wait_rsp(3);

    // T3: read with response back-pressure
    rdy_delay     = 1;
    s_axil_rready = 1'b0;
    exp_nat.push_back('{1'b0, 32'h24, 32'h0, 4'h0});
    exp_rsp.push_back('{1'b1, 32'h1234_5678});
    send_ar(32'h24);
    for (int i = 0; i < 50 && !s_axil_rvalid; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rvalid_hold", 32'(s_axil_rvalid), 32'(1));
      chk("t3_rdata_hold", s_axil_rdata, 32'h1234_5678);
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_axil_rready = 1'b1;
    wait_rsp(4);

    // T4: write and read requested together twice; previous grant was a read
    rdy_delay = 0;
    exp_nat.push_back('{1'b1, 32'h40, 32'h1111_2222, 4'hF});
    exp_nat.push_back('{1'b0, 32'h44, 32'h0, 4'h0});
    exp_nat.push_back('{1'b1, 32'h48, 32'h3333_4444, 4'hF});
    exp_nat.push_back('{1'b0, 32'h4C, 32'h0, 4'h0});
    exp_rsp.push_back('{1'b0, 32'h0});
    exp_rsp.push_back('{1'b1, 32'hA5A5_0044});
    exp_rsp.push_back('{1'b0, 32'h0});
    exp_rsp.push_back('{1'b1, 32'hA5A5_004C});
    fork
      begin send_aw(32'h40); send_aw(32'h48); end
      begin send_w(32'h1111_2222, 4'hF); send_w(32'h3333_4444, 4'hF); end
      begin send_ar(32'h44); send_ar(32'h4C); end
    join
    wait_rsp(8);

    // T6: reset in the middle of a read whose native side never answers
    hang = 1'b1;
    send_ar(32'h50);
    @(negedge clk);
    chk("t6_iob_valid_before", 32'(iob_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6_iob_valid_async", 32'(iob_valid), 32'(0));
    chk("t6_rvalid_async", 32'(s_axil_rvalid), 32'(0));
    chk("t6_bvalid_async", 32'(s_axil_bvalid), 32'(0));
    @(posedge clk); #1;
    rst  = 1'b0;
    hang = 1'b0;
    exp_nat.push_back('{1'b0, 32'h60, 32'h0, 4'h0});
    exp_rsp.push_back('{1'b1, 32'hA5A5_0060});
    send_ar(32'h60);
    wait_rsp(9);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("nat_queue_drained", 32'(exp_nat.size()), 32'(0));
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
